// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package rf_dump_pkg;
  localparam int NREGS = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_START = 2'd1,
    CAUSE_LIMIT = 2'd2,
    CAUSE_PC    = 2'd3
  } cause_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && cnt != {W{1'b1}})
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rf_dump_ctrl.sv
// End-of-run dump engine: waits for a stop trigger, then streams all
// architectural registers out over a valid/ready port.
module rf_dump_ctrl
  import rf_dump_pkg::*;
#(
  parameter int          MAX_CYCLES = 100,
  parameter logic [31:0] HALT_PC    = 32'h0000_0060,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             halt_en,
  input  logic [31:0]      pc_in,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [31:0]      dump_data,
  output logic [4:0]       dump_idx,
  output logic             dump_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       stop_cause
);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  cause_t           trig_cause;

  // Counting stops the moment we leave IDLE, which also freezes it in DONE.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .inc (state == S_IDLE && en),
    .cnt (cycle_cnt)
  );

  always_comb begin
    trig_cause = CAUSE_NONE;
    if (start)
      trig_cause = CAUSE_START;
    else if (halt_en && pc_in == HALT_PC)
      trig_cause = CAUSE_PC;
    else if (MAX_CYCLES != 0 && en && cycle_cnt == LIMIT_M1)
      trig_cause = CAUSE_LIMIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      reg_sel    <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stop_cause <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: if (trig_cause != CAUSE_NONE) begin
          state      <= S_FETCH;
          idx        <= '0;
          reg_sel    <= '0;
          busy       <= 1'b1;
          stop_cause <= trig_cause;
        end
        S_FETCH: begin
          // x0 is architecturally zero whatever the port returns.
          dump_data  <= (idx == '0) ? 32'd0 : reg_data;
          dump_idx   <= idx;
          dump_last  <= (idx == LAST_IDX);
          dump_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: if (dump_ready) begin
          dump_valid <= 1'b0;
          if (idx == LAST_IDX) begin
            state   <= S_DONE;
            reg_sel <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state   <= S_FETCH;
            idx     <= idx + 1'b1;
            reg_sel <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Directed bench for rf_dump_ctrl: limit/PC/start triggers, backpressure,
// mid-dump reset, terminal state and counter saturation.
module tb_rf_dump_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, start, halt_en, dump_ready;
  logic [31:0] pc_in, reg_data, dump_data;
  logic [4:0]  reg_sel, dump_idx;
  logic        dump_valid, dump_last, busy, done;
  logic [15:0] cycle_cnt;
  logic [1:0]  stop_cause;

  logic        rst2, en2, start2, halt_en2, dump_ready2;
  logic [31:0] pc_in2, reg_data2, dump_data2;
  logic [4:0]  reg_sel2, dump_idx2;
  logic        dump_valid2, dump_last2, busy2, done2;
  logic [3:0]  cycle_cnt2;
  logic [1:0]  stop_cause2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Register-file model: rf[k] = k*0x11, with a nonzero x0 to prove masking.
  assign reg_data  = (reg_sel == 5'd0) ? 32'h0000_DEAD : 32'(reg_sel) * 32'h11;
  assign reg_data2 = 32'h1234_5678;

  rf_dump_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .halt_en(halt_en),
    .pc_in(pc_in), .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt), .stop_cause(stop_cause)
  );

  rf_dump_ctrl #(.MAX_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .en(en2), .start(start2), .halt_en(halt_en2),
    .pc_in(pc_in2), .reg_sel(reg_sel2), .reg_data(reg_data2),
    .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_data(dump_data2),
    .dump_idx(dump_idx2), .dump_last(dump_last2), .busy(busy2), .done(done2),
    .cycle_cnt(cycle_cnt2), .stop_cause(stop_cause2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called in cycle T+1 (first cycle after the trigger edge). Consumes the
  // whole dump, optionally stalling 3 cycles on stall_idx.
  task automatic collect(input int stall_idx, input int exp_done);
    int k = 0;
    int cyc = 1;
    int stalls = 3;
    bit seen = 0;
    int exp_cyc;
    while (cyc < 200 && !done) begin
      if (dump_valid) begin
        chk("word_data", dump_data, (k == 0) ? 32'd0 : 32'(k) * 32'h11);
        chk("word_idx", 32'(dump_idx), 32'(k));
        chk("word_last", 32'(dump_last), 32'(k == 31));
        if (!seen) begin
          exp_cyc = 2 + 2 * k + ((stall_idx >= 0 && k > stall_idx) ? 3 : 0);
          chk("word_cycle", 32'(cyc), 32'(exp_cyc));
          seen = 1;
        end
        if (k == stall_idx && stalls > 0) begin
          dump_ready = 1'b0;
          stalls--;
        end else begin
          dump_ready = 1'b1;
          k++;
          seen = 0;
        end
      end else begin
        dump_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b1;
    chk("done_cycle", 32'(cyc), 32'(exp_done));
    chk("word_count", 32'(k), 32'd32);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; start = 1'b0; halt_en = 1'b0; pc_in = '0; dump_ready = 1'b1;
    rst2 = 1'b1; en2 = 1'b0; start2 = 1'b0; halt_en2 = 1'b0; pc_in2 = '0; dump_ready2 = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_cause", 32'(stop_cause), 32'd0);
    chk("rst_sel", 32'(reg_sel), 32'd0);
    chk("rst_data", dump_data, 32'd0);

    // Cycle limit: trigger on the 100th counted edge
    en = 1'b1;
    repeat (99) tick();
    chk("lim_pre_busy", 32'(busy), 32'd0);
    chk("lim_pre_cnt", 32'(cycle_cnt), 32'd99);
    tick();
    chk("lim_busy", 32'(busy), 32'd1);
    chk("lim_cause", 32'(stop_cause), 32'd2);
    chk("lim_cnt", 32'(cycle_cnt), 32'd100);
    collect(-1, 65);
    chk("lim_cnt_frozen", 32'(cycle_cnt), 32'd100);
    chk("lim_cause_frozen", 32'(stop_cause), 32'd2);

    // Terminal: start after done does nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      chk("term_valid", 32'(dump_valid), 32'd0);
      chk("term_done", 32'(done), 32'd1);
      chk("term_busy", 32'(busy), 32'd0);
      tick();
    end
    chk("term_cause", 32'(stop_cause), 32'd2);

    // PC halt at cycle 40, with 3-cycle backpressure on idx 5
    do_reset();
    chk("rst2_done", 32'(done), 32'd0);
    en = 1'b1; halt_en = 1'b1; pc_in = 32'h0;
    repeat (39) tick();
    pc_in = 32'h60;
    tick();
    pc_in = 32'h0;
    chk("pc_cause", 32'(stop_cause), 32'd3);
    chk("pc_cnt", 32'(cycle_cnt), 32'd40);
    collect(5, 68);
    halt_en = 1'b0;

    // Simultaneous triggers: start wins
    do_reset();
    en = 1'b1;
    repeat (99) tick();
    start = 1'b1; halt_en = 1'b1; pc_in = 32'h60;
    tick();
    start = 1'b0; halt_en = 1'b0; pc_in = 32'h0;
    chk("simul_cause", 32'(stop_cause), 32'd1);
    chk("simul_cnt", 32'(cycle_cnt), 32'd100);

    // Reset mid-dump while word 12 is waiting in SEND
    guard = 0;
    while (!(dump_valid && dump_idx == 5'd12) && guard < 100) begin
      tick();
      guard++;
    end
    chk("mid_reach_idx12", 32'(guard < 100), 32'd1);
    dump_ready = 1'b0;
    chk("mid_sel", 32'(reg_sel), 32'd12);
    do_reset();
    dump_ready = 1'b1;
    en = 1'b0;
    chk("mid_valid", 32'(dump_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sel0", 32'(reg_sel), 32'd0);
    chk("mid_cnt", 32'(cycle_cnt), 32'd0);
    chk("mid_cause", 32'(stop_cause), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_cause", 32'(stop_cause), 32'd1);
    chk("restart_cnt", 32'(cycle_cnt), 32'd0);
    collect(-1, 65);

    // Saturation with limit disabled on the narrow instance
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    en2 = 1'b1;
    repeat (14) tick();
    chk("sat_cnt14", 32'(cycle_cnt2), 32'd14);
    repeat (6) tick();
    chk("sat_cnt15", 32'(cycle_cnt2), 32'd15);
    chk("sat_busy", 32'(busy2), 32'd0);
    chk("sat_valid", 32'(dump_valid2), 32'd0);
    chk("sat_cause", 32'(stop_cause2), 32'd0);
    chk("sat_done", 32'(done2), 32'd0);
    chk("sat_sel", 32'(reg_sel2), 32'd0);
    chk("sat_data", dump_data2, 32'd0);
    chk("sat_idx", 32'(dump_idx2), 32'd0);
    chk("sat_last", 32'(dump_last2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_dump_ctrl.md
# rf_dump_ctrl

End-of-run register-file dump engine for the pipelined RISC-V core. Sits directly downstream of `sccomp`: counts cycles, detects a stop condition (cycle limit, halt PC or explicit start), then walks all 32 architectural registers through the `reg_sel`/`reg_data` debug port. Each value is emitted on a valid/ready stream for a UART/trace sink, making the run-and-dump check available in hardware.

## Interface
- `MAX_CYCLES`, 100: cycle-limit trigger; 0 disables the limit trigger.
- `HALT_PC`, 32'h0000_0060: PC value that triggers the dump when `halt_en`=1.
- `CNT_W`, 16: width of `cycle_cnt`.
- `clk` in 1: the single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: cycle counting enable; typically tied to the core's run state.
- `start` in 1: single-cycle request to dump immediately.
- `halt_en` in 1: enables the PC-match trigger.
- `pc_in` in 32: core PC, from `sccomp` `PC`.
- `reg_sel` out 5: register index to `sccomp`.
- `reg_data` in 32: combinational read data for `reg_sel`.
- `dump_valid` out 1: stream word valid.
- `dump_ready` in 1: sink accepts the word.
- `dump_data` out 32: register value.
- `dump_idx` out 5: register index of `dump_data`.
- `dump_last` out 1: high with index 31.
- `busy` out 1: dump in progress.
- `done` out 1: sticky; dump complete.
- `cycle_cnt` out CNT_W: cycles counted while in IDLE with `en`=1.
- `stop_cause` out 2: 0 none, 1 start, 2 cycle limit, 3 PC match.

## Operation
- The FSM has four states:
  - IDLE: while `en`=1, `cycle_cnt` increments and saturates at all-ones. The block triggers on the first of `start`, `halt_en && pc_in==HALT_PC`, or `MAX_CYCLES!=0 && cycle_cnt==MAX_CYCLES-1 && en`.
  - FETCH: drives `reg_sel`=idx. At the clock edge it latches `dump_data`, `dump_idx` and `dump_last`, then moves to SEND.
  - SEND: `dump_valid`=1 until the cycle in which `dump_ready`=1.
    - On the handshake with idx==31 → DONE.
    - On any other handshake, idx+1 → FETCH.
  - DONE: terminal. `done`=1, and `cycle_cnt` and `stop_cause` are frozen. Only `rst` leaves DONE. Triggers are ignored.
- On a trigger, IDLE → FETCH with idx=0, and `stop_cause` is latched.
- Triggers in the same cycle resolve by priority: start > PC match > cycle limit.
- Register 0: `dump_data` is forced to 0, independent of `reg_data`.
- `reg_sel` holds idx in FETCH and SEND, and is 0 in IDLE and DONE.
- Stream rule: while `dump_valid`=1 and `dump_ready`=0, `dump_data`, `dump_idx` and `dump_last` stay stable. `dump_valid` never drops without a handshake, except on `rst`.
- `busy`=1 in FETCH and SEND.
- Triggers arriving in FETCH or SEND are ignored; `cycle_cnt` does not count there.
- On reset, all outputs are 0, the state is IDLE, `cycle_cnt`=0 and `stop_cause`=0. A reset mid-dump aborts the dump, and `dump_valid` is 0 in the cycle after the reset edge.

## Timing
- A trigger sampled at edge T gives FETCH in cycle T+1. The first `dump_valid` is in cycle T+2.
- Throughput is one word per 2 cycles when `dump_ready` is held high. Register k is valid in cycle T+2+2k, and register 31 in T+64.
- `done` rises in cycle T+65. `busy` is high in cycles T+1..T+64.
- Each stall cycle (`dump_ready`=0) adds exactly one cycle to all later events.
- `reg_data` must settle within the FETCH cycle; the read is a single-cycle combinational path.

## Structure
- Shared package `rf_dump_pkg` holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - the `stop_cause` codes;
  - the constant NREGS=32.
- One sub-module, `sat_counter`: parameterised saturating up-counter with enable and synchronous clear, used for `cycle_cnt`.
- The FSM, index counter and output registers live in `rf_dump_ctrl`.

## Test plan
- Cycle limit: `en`=1, `MAX_CYCLES`=100, `dump_ready`=1, model rf[k]=k*0x11 (rf[0] model 0xDEAD).
  - `stop_cause`=2 and `cycle_cnt`=100.
  - 32 words with idx 0..31; word 0 is 0 and word k is k*0x11.
  - `dump_last` is high only on idx 31; `done` rises 65 cycles after the trigger.
- PC halt: `halt_en`=1, `pc_in`=0x60 at cycle 40 → `stop_cause`=3 and `cycle_cnt`=40.
- Simultaneous triggers: `start`, PC match and limit in the same cycle → `stop_cause`=1.
- Backpressure:
  - `dump_ready` low for 3 cycles on idx 5 → idx 5 data is held stable and `dump_valid` stays high.
  - All later events shift by 3; `done` rises at T+68.
- Reset mid-dump: `rst` during SEND at idx 12.
  - Next cycle: `dump_valid`=0, `busy`=0, `reg_sel`=0, `cycle_cnt`=0.
  - A new `start` then dumps from idx 0.
- Terminal and saturation: `start` after `done` → no new words and `done` stays 1. `MAX_CYCLES`=0 with `CNT_W`=4 → `cycle_cnt` saturates at 15 and no trigger fires.
